alu_result_skid: RTL and testbench

//  Registered output stage directly downstream of the 32-bit ALU logic units (and/or/xor/add).

---
 rtl/alu_result_skid.sv | 154 +++++++++++++++
 tb/tb_alu_result_skid.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/alu_result_skid.sv
// alu_result_skid
//   Registered output stage behind the 32-bit ALU logic units. Each ALU result
//   and its op tag are captured through a valid/ready handshake into a 2-entry
//   skid buffer, so in_ready is a plain flop and there is no combinational path
//   from the input side to the output side. The result is presented with a zero
//   flag to the writeback/consumer stage.
//
//   Optional feature macro: ALU_RES_PARITY_EN
//     defined   -> out_parity port exists (^out_res, registered with the data),
//                  and the skid entry carries parity too.
//     undefined -> no out_parity port, no parity flops.
//
// Ports
//   clk         in   1    rising-edge clock
//   rst_n       in   1    asynchronous active-low reset
//   in_valid    in   1    ALU result valid
//   in_ready    out  1    stage can accept (registered)
//   in_res      in   W    ALU result
//   in_op       in   OPW  op tag of in_res (carried, not interpreted)
//   out_valid   out  1    out_res/out_op/out_zero valid
//   out_ready   in   1    consumer accepts
//   out_res     out  W    oldest buffered result
//   out_op      out  OPW  op tag of out_res
//   out_zero    out  1    out_res == 0
//   out_parity  out  1    ^out_res (ALU_RES_PARITY_EN only)
//
// State table
//   state   | meaning
//   S_EMPTY | nothing buffered; out_valid=0, in_ready=1
//   S_ONE   | main holds an entry; out_valid=1, in_ready=1
//   S_TWO   | main and skid hold entries; out_valid=1, in_ready=0

module alu_result_skid #(
  parameter int W   = 32,
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_res,
  input  logic [OPW-1:0] in_op,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_res,
  output logic [OPW-1:0] out_op,
  output logic           out_zero
`ifdef ALU_RES_PARITY_EN
  ,
  output logic           out_parity
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t         state;
  logic [W-1:0]   skid_res;
  logic [OPW-1:0] skid_op;
`ifdef ALU_RES_PARITY_EN
  logic           skid_parity;
`endif

  logic accept;
  logic pop;

  // in_ready is only ever high in EMPTY/ONE, so accept never fires in TWO and
  // in_valid is naturally ignored there.
  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  // out_res/out_op/out_zero (and out_parity) are the main register itself; they
  // only change on a load, so they hold while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_res   <= '0;
      out_op    <= '0;
      out_zero  <= 1'b1;
      skid_res  <= '0;
      skid_op   <= '0;
`ifdef ALU_RES_PARITY_EN
      out_parity  <= 1'b0;
      skid_parity <= 1'b0;
`endif
    end else begin
      case (state)
        S_EMPTY: begin
          if (accept) begin
            out_res   <= in_res;
            out_op    <= in_op;
            out_zero  <= (in_res == '0);
`ifdef ALU_RES_PARITY_EN
            out_parity <= ^in_res;
`endif
            out_valid <= 1'b1;
            in_ready  <= 1'b1;
            state     <= S_ONE;
          end
        end

        S_ONE: begin
          if (accept && pop) begin
            // Stream-through: the new result replaces the one just consumed.
            out_res  <= in_res;
            out_op   <= in_op;
            out_zero <= (in_res == '0);
`ifdef ALU_RES_PARITY_EN
            out_parity <= ^in_res;
`endif
          end else if (pop) begin
            out_valid <= 1'b0;
            state     <= S_EMPTY;
          end else if (accept) begin
            // Consumer stalled: park the younger entry in skid and drop
            // in_ready for next cycle (that is the registered-ready cost).
            skid_res <= in_res;
            skid_op  <= in_op;
`ifdef ALU_RES_PARITY_EN
            skid_parity <= ^in_res;
`endif
            in_ready <= 1'b0;
            state    <= S_TWO;
          end
        end

        S_TWO: begin
          if (pop) begin
            out_res  <= skid_res;
            out_op   <= skid_op;
            out_zero <= (skid_res == '0);
`ifdef ALU_RES_PARITY_EN
            out_parity <= skid_parity;
`endif
            in_ready <= 1'b1;
            state    <= S_ONE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_skid.sv
module tb_alu_result_skid;

  localparam int W   = 32;
  localparam int OPW = 3;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_res;
  logic [OPW-1:0] in_op;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_res;
  logic [OPW-1:0] out_op;
  logic           out_zero;
`ifdef ALU_RES_PARITY_EN
  logic           out_parity;
`endif

  int n_cmp = 0;
  int n_err = 0;

  alu_result_skid #(.W(W), .OPW(OPW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_res    (in_res),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_op    (out_op),
    .out_zero  (out_zero)
`ifdef ALU_RES_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are then driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_res    = '0;
    in_op     = '0;
    out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_res",   out_res,        32'd0);
    chk("rst_out_op",    32'(out_op),    32'd0);
    chk("rst_out_zero",  32'(out_zero),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single beat
    in_valid  = 1'b1;
    in_res    = 32'hF0F0_0F0F;
    in_op     = 3'd1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_res",   out_res,        32'hF0F0_0F0F);
    chk("single_op",    32'(out_op),    32'd1);
    chk("single_zero",  32'(out_zero),  32'd0);
    step();
    chk("single_empty", 32'(out_valid), 32'd0);

    // Backpressure
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_res    = 32'h1;
    in_op     = 3'd2;
    step();
    chk("bp_one_ready", 32'(in_ready), 32'd1);
    in_res = 32'h2;
    in_op  = 3'd3;
    step();
    chk("bp_two_ready", 32'(in_ready),  32'd0);
    chk("bp_two_valid", 32'(out_valid), 32'd1);
    chk("bp_two_res",   out_res,        32'h1);
    in_res = 32'h3;
    in_op  = 3'd4;
    step();
    chk("bp_hold_ready", 32'(in_ready), 32'd0);
    chk("bp_hold_res",   out_res,       32'h1);
    chk("bp_hold_op",    32'(out_op),   32'd2);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_pop1_res",   out_res,        32'h2);
    chk("bp_pop1_op",    32'(out_op),    32'd3);
    chk("bp_pop1_valid", 32'(out_valid), 32'd1);
    chk("bp_pop1_ready", 32'(in_ready),  32'd1);
    step();
    chk("bp_drained", 32'(out_valid), 32'd0);
    step();
    chk("bp_no_third", 32'(out_valid), 32'd0);

    // Streaming 0..99
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_res   = 32'(i);
      in_op    = 3'(i);
      step();
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_ready", 32'(in_ready),  32'd1);
      chk("stream_res",   out_res,        32'(i));
      chk("stream_op",    32'(out_op),    32'(i % 8));
      chk("stream_zero",  32'(out_zero),  (i == 0) ? 32'd1 : 32'd0);
    end
    in_valid = 1'b0;
    step();
    chk("stream_end", 32'(out_valid), 32'd0);

    // Reset while two entries are held
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_res    = 32'hA;
    in_op     = 3'd5;
    step();
    in_res = 32'hB;
    step();
    in_valid = 1'b0;
    chk("rst2_pre_ready", 32'(in_ready), 32'd0);
    chk("rst2_pre_res",   out_res,       32'hA);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst2_valid", 32'(out_valid), 32'd0);
    chk("rst2_ready", 32'(in_ready),  32'd1);
    chk("rst2_res",   out_res,        32'd0);
    chk("rst2_op",    32'(out_op),    32'd0);
    chk("rst2_zero",  32'(out_zero),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    in_valid = 1'b1;
    in_res   = 32'hC;
    in_op    = 3'd6;
    step();
    in_valid = 1'b0;
    chk("rst2_c_valid", 32'(out_valid), 32'd1);
    chk("rst2_c_res",   out_res,        32'hC);
    chk("rst2_c_op",    32'(out_op),    32'd6);
    out_ready = 1'b1;
    step();
    chk("rst2_c_only", 32'(out_valid), 32'd0);

`ifdef ALU_RES_PARITY_EN
    // Parity, including through the skid path
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_res    = 32'h0000_0007;
    step();
    in_res = 32'h0000_0003;
    step();
    in_valid = 1'b0;
    chk("par_7", 32'(out_parity), 32'd1);
    out_ready = 1'b1;
    step();
    chk("par_3_res", out_res,         32'h3);
    chk("par_3",     32'(out_parity), 32'd0);
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
